bfm_ahbl_slave_mem: RTL

AHB-Lite responder bus-functional model: a byte-addressable memory slave with programmable wait states and an error response. It is the target-side counterpart of the team's AHB-Lite master BFM. Testbenches connect it to the master BFM's HADDR/HTRANS/HWRITE/HSIZE/HWDATA outputs and one HSEL bit. Vector scripts can then exercise writes, reads, waits and errors without a real peripheral.

---
 rtl/bfm_ahbl_slave_pkg.sv | 47 ++++
 rtl/bfm_ahbl_slave_mem_ram.sv | 31 +++
 rtl/bfm_ahbl_slave_mem.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/bfm_ahbl_slave_pkg.sv
// Shared AHB-Lite codes, responder FSM states and byte-lane decode for the
// bfm_ahbl_slave_mem responder model.
package bfm_ahbl_slave_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_e;

    // Only NONSEQ and SEQ carry a transfer.
    function automatic logic htrans_active(input logic [1:0] htrans);
        logic active;
        case (htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  active = 1'b0;
            default:                   active = 1'b0;
        endcase
        return active;
    endfunction

    // Little-endian lanes; sub-word offsets below the size alignment are ignored.
    function automatic logic [3:0] lane_decode(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] lanes;
        case (size)
            HSIZE_BYTE: lanes = 4'b0001 << addr_lo;
            HSIZE_HALF: lanes = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:    lanes = 4'b1111;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/bfm_ahbl_slave_mem_ram.sv
// Word-organised storage for the responder: byte-enable write port and
// asynchronous read port. Contents are never reset.
module bfm_ahbl_slave_ram
    import bfm_ahbl_slave_pkg::*;
#(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [3:0]               wr_be,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [31:0]              wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [31:0]              rd_data
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/bfm_ahbl_slave_mem.sv
// AHB-Lite memory responder BFM with fixed wait states per OKAY data phase.
// Define BFM_AHBL_SLAVE_ERROR_EN to answer out-of-range/misaligned/oversize transfers with ERROR.
module bfm_ahbl_slave_mem
    import bfm_ahbl_slave_pkg::*;
#(
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned TPD         = 1
) (
    input  logic        HCLK,
    input  logic        HRESETN,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADYIN,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int unsigned AW = $clog2(MEM_DEPTH);
    localparam int unsigned CW = 4;

    state_e          state_q, state_d;
    logic [CW-1:0]   wcnt_q, wcnt_d;
    logic [AW-1:0]   word_q;
    logic            write_q;
    logic [3:0]      be_q;
    logic            hreadyout_q, hreadyout_d;
    logic            hresp_q, hresp_d;
    logic [31:0]     hrdata_q, hrdata_d;

    logic            accept_c;
    logic            err_c;
    logic            commit_c;
    logic            rd_load_c;
    logic            fwd_c;
    logic [AW-1:0]   word_c;
    logic [3:0]      be_c;
    logic [AW-1:0]   rd_addr_c;
    logic [31:0]     ram_rdata_c;
    logic [31:0]     rd_word_c;
    logic            unused_c;

    // Address phase sampled only while our previous data phase is completing.
    assign accept_c = HSEL & HREADYIN & htrans_active(HTRANS) & hreadyout_q;
    assign word_c   = HADDR[AW+1:2];
    assign be_c     = lane_decode(HSIZE, HADDR[1:0]);

`ifdef BFM_AHBL_SLAVE_ERROR_EN
    assign err_c = (|HADDR[31:AW+2])
                 | (HSIZE > HSIZE_WORD)
                 | ((HSIZE == HSIZE_HALF) & HADDR[0])
                 | ((HSIZE == HSIZE_WORD) & (|HADDR[1:0]));
`else
    assign err_c = 1'b0;
`endif

    assign unused_c = ^{HBURST, HADDR[31:AW+2], TPD};

    assign commit_c  = (state_q == ST_DATA) & write_q;
    assign rd_addr_c = accept_c ? word_c : word_q;

    bfm_ahbl_slave_ram #(
        .DEPTH (MEM_DEPTH)
    ) u_ram (
        .clk     (HCLK),
        .wr_en   (commit_c & HRESETN),
        .wr_be   (be_q),
        .wr_addr (word_q),
        .wr_data (HWDATA),
        .rd_addr (rd_addr_c),
        .rd_data (ram_rdata_c)
    );

    // A read loaded on the same edge a write to its word commits sees the new lanes.
    assign fwd_c = commit_c & (rd_addr_c == word_q);

    always_comb begin
        rd_word_c = ram_rdata_c;
        if (fwd_c) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    rd_word_c[8*i +: 8] = HWDATA[8*i +: 8];
                end
            end
        end
    end

    // Next state and next registered outputs.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        hreadyout_d = 1'b1;
        hresp_d     = HRESP_OKAY;
        rd_load_c   = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (wcnt_q <= CW'(1)) begin
                    state_d   = ST_DATA;
                    wcnt_d    = '0;
                    rd_load_c = ~write_q;
                end else begin
                    wcnt_d      = wcnt_q - CW'(1);
                    hreadyout_d = 1'b0;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
                hresp_d = HRESP_ERROR;
            end
            default: begin
                if (accept_c) begin
                    if (err_c) begin
                        state_d     = ST_ERR1;
                        hreadyout_d = 1'b0;
                        hresp_d     = HRESP_ERROR;
                    end else if (WAIT_STATES > 0) begin
                        state_d     = ST_WAIT;
                        wcnt_d      = CW'(WAIT_STATES);
                        hreadyout_d = 1'b0;
                    end else begin
                        state_d   = ST_DATA;
                        rd_load_c = ~HWRITE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
        hrdata_d = rd_load_c ? rd_word_c : '0;
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETN) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= '0;
            word_q      <= '0;
            write_q     <= 1'b0;
            be_q        <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            hrdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
            if (accept_c) begin
                word_q  <= word_c;
                write_q <= HWRITE;
                be_q    <= be_c;
            end
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = hrdata_q;

endmodule
